blink_arbiter: RTL and testbench
================================

Name: blink_arbiter

Overview:
- Shares one blinking indicator (`light`) among NREQ requesters.
- Each requester asks for the light with its own half-period. A round-robin scheduler grants one owner at a time.
- The owner's blink sequence runs for BLINKS full on/off cycles, then a completion pulse is issued.
- Sits between status sources (FSMs, error flags) and the single board LED.

Parameters:
- NREQ, 4, number of requesters (2..8)
- CW, 7, width of the phase counter and of each half-period field
- BLINKS, 4, full on/off cycles per grant (1..2^(CW-1))

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  NREQ  level request per requester; held until done or withdrawn
- half_period  input  NREQ*CW  packed terminal counts; slice i = [i*CW +: CW]; phase length = value+1 cycles
- grant  output  NREQ  one-hot current owner, all-zero when idle
- done  output  NREQ  one-cycle pulse to the owner on normal completion
- light  output  1  indicator drive
- busy  output  1  high while a grant is active (= |grant)

Behaviour:
- Reset values (async, immediate): grant=0, done=0, light=0, busy=0, state=IDLE, cnt=0, tog=0, ptr=0, hp_reg=0.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, RUN. The state type is two-valued.
- IDLE, no req bit set: hold; done drops to 0 after its one cycle.
- IDLE, any req set: winner = first set bit scanning indices ptr, ptr+1, … wrapping mod NREQ. At the next edge:
  - grant<=onehot(winner), hp_reg<=half_period slice of winner, cnt<=0, tog<=0, light<=1, state<=RUN.
  - Latency from req sampled high in IDLE to grant/light high: 1 cycle.
- hp_reg is captured once per grant. half_period changes during RUN are ignored.
- RUN, req[owner] low (abort, highest priority):
  - At the next edge: light<=0, grant<=0, state<=IDLE, ptr<=owner+1 mod NREQ.
  - done is not pulsed.
- RUN, req[owner] high, cnt!=hp_reg: cnt<=cnt+1.
- RUN, req[owner] high, cnt==hp_reg: cnt<=0, light<=~light, tog<=tog+1.
- Completion: when this toggle is number 2*BLINKS (tog==2*BLINKS-1 before the edge), at the same edge:
  - light<=0, grant<=0, done[owner]<=1, state<=IDLE, ptr<=owner+1 mod NREQ.
- Phase timing: each on and off phase lasts hp_reg+1 cycles. Total grant length is 2*BLINKS*(hp_reg+1) cycles. light ends low.
- hp_reg=0: light toggles every cycle. hp_reg=2^CW-1: phases of 2^CW cycles; cnt must not wrap before the compare.
- tog width: clog2(2*BLINKS)+1 bits. No overflow is possible.
- Back-to-back grants: the cycle where done is high is spent in IDLE, with arbitration active in that cycle. The next grant appears 1 cycle later, so there is a minimum 1-cycle gap with light=0.
- New requests arriving during RUN wait. There is no preemption.
- A requester that re-asserts req after done competes normally. The rotated ptr gives other requesters priority first.
- rst asserted mid-RUN: light, grant and done go low immediately. After release, arbitration restarts from ptr=0.

Decomposition:
- Package blink_pkg:
  - state enum {IDLE, RUN}
  - localparam helpers: clog2 of NREQ and of 2*BLINKS
  - function onehot(idx)
- Sub-module rr_picker (combinational):
  - inputs req[NREQ], ptr
  - outputs valid and winner index
  - rotate-and-priority-encode
- The top holds the FSM, counters, ptr and the output registers.

Test Plan:
- Single requester: req=0001, hp0=24, BLINKS=4.
  - grant=0001 and light=1 one cycle after req.
  - light toggles every 25 cycles, 8 toggles.
  - done[0] pulses once at cycle 200 of the grant; light=0, grant=0.
- Round robin: req=1111 held, all hp=1.
  - Grants in order 0001, 0010, 0100, 1000, 0001.
  - Each grant lasts 16 cycles, with a 1-cycle gap where done pulses for the previous owner.
- Abort: req0 dropped 10 cycles into a grant with hp=24.
  - Next edge: light=0, grant=0, no done.
  - ptr=1, so a pending req[2] is granted next.
- Latching: half_period slice changed from 24 to 3 mid-RUN.
  - Phases stay 25 cycles until done.
  - The next grant uses 3, i.e. 4-cycle phases.
- Boundaries: hp=0 gives toggles every cycle, 8-cycle grant; hp=127 gives 128-cycle phases with no counter wrap error.
- Reset mid-RUN: rst pulsed at cycle 37 of a grant.
  - grant, light and done are 0 asynchronously, before the next clock edge.
  - After release, req=1010 grants index 1 first (ptr=0).

Source files
------------

// File: rtl/blink_pkg.sv
// Shared types and helpers for the blink arbiter.
//   state_t     : arbiter FSM states
//   ptr_width() : bits needed to index NREQ requesters (at least 1)
//   tog_width() : bits for the toggle counter, holds 0..2*BLINKS
//   onehot()    : index to one-hot vector, up to 8 requesters
package blink_pkg;

  localparam int unsigned MAX_NREQ = 8;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned tog_width(input int unsigned blinks);
    return $clog2(2 * blinks) + 1;
  endfunction

  function automatic logic [MAX_NREQ-1:0] onehot(input logic [2:0] idx);
    logic [MAX_NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req    : request vector
//   ptr    : index with highest priority this round
//   valid  : at least one request set
//   winner : first set index scanning ptr, ptr+1, ... modulo NREQ
module rr_picker #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            valid,
  output logic [PW-1:0]   winner
);

  logic [PW-1:0] cand;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = PW'((32'(ptr) + i) % NREQ);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/blink_arbiter.sv
// Shares one blinking indicator among NREQ requesters.
//   clk, rst    : clock, asynchronous active-high reset
//   req         : level request per requester
//   half_period : packed terminal counts, slice i = [i*CW +: CW]
//   grant       : one-hot current owner (registered)
//   done        : one-cycle completion pulse to the owner (registered)
//   light       : indicator drive (registered)
//   busy        : high while a grant is active
module blink_arbiter
  import blink_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned CW     = 7,
  parameter int unsigned BLINKS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CW-1:0]   half_period,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 light,
  output logic                 busy
);

  localparam int unsigned    PW       = ptr_width(NREQ);
  localparam int unsigned    TW       = tog_width(BLINKS);
  localparam logic [PW-1:0]  LAST_IDX = PW'(NREQ - 1);
  localparam logic [TW-1:0]  TOG_LAST = TW'(2 * BLINKS - 1);

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n, hp_reg, hp_n;
  logic [TW-1:0]     tog, tog_n;
  logic [PW-1:0]     ptr, ptr_n, owner, owner_n, next_ptr;
  logic [NREQ-1:0]   grant_n, done_n;
  logic              light_n;
  logic              pick_valid;
  logic [PW-1:0]     pick_idx;
  logic [MAX_NREQ-1:0] pick_oh, owner_oh;

  rr_picker #(.NREQ(NREQ), .PW(PW)) u_picker (
    .req    (req),
    .ptr    (ptr),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  assign pick_oh  = onehot(3'(pick_idx));
  assign owner_oh = onehot(3'(owner));
  assign next_ptr = (owner == LAST_IDX) ? '0 : owner + 1'b1;
  assign busy     = |grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      hp_reg <= '0;
      tog    <= '0;
      ptr    <= '0;
      owner  <= '0;
      grant  <= '0;
      done   <= '0;
      light  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      hp_reg <= hp_n;
      tog    <= tog_n;
      ptr    <= ptr_n;
      owner  <= owner_n;
      grant  <= grant_n;
      done   <= done_n;
      light  <= light_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hp_n    = hp_reg;
    tog_n   = tog;
    ptr_n   = ptr;
    owner_n = owner;
    grant_n = grant;
    done_n  = '0;
    light_n = light;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          owner_n = pick_idx;
          grant_n = pick_oh[NREQ-1:0];
          hp_n    = half_period[pick_idx*CW +: CW];
          cnt_n   = '0;
          tog_n   = '0;
          light_n = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        // Withdrawal beats any phase activity in the same cycle.
        if (!req[owner]) begin
          light_n = 1'b0;
          grant_n = '0;
          ptr_n   = next_ptr;
          state_n = IDLE;
        end else if (cnt != hp_reg) begin
          cnt_n = cnt + 1'b1;
        end else begin
          cnt_n   = '0;
          light_n = ~light;
          tog_n   = tog + 1'b1;
          if (tog == TOG_LAST) begin
            light_n = 1'b0;
            grant_n = '0;
            done_n  = owner_oh[NREQ-1:0];
            ptr_n   = next_ptr;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_blink_arbiter.sv
module tb_blink_arbiter;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned CW     = 7;
  localparam int unsigned BLINKS = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*CW-1:0] half_period = '0;
  logic [NREQ-1:0]   grant, done;
  logic              light, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  blink_arbiter #(.NREQ(NREQ), .CW(CW), .BLINKS(BLINKS)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .half_period (half_period),
    .grant       (grant),
    .done        (done),
    .light       (light),
    .busy        (busy)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    total++;
    if (grant !== 4'b0 || done !== 4'b0 || light !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_async grant=%b done=%b light=%b busy=%b required all 0", grant, done, light, busy);
    end
    step(1);
    total++;
    if (grant !== 4'b0 || done !== 4'b0 || light !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_held grant=%b done=%b light=%b busy=%b required all 0", grant, done, light, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int errs;
    logic exp_l;
    do_reset();
    half_period = {4{7'd24}};
    req = 4'b0001;
    step(1);
    total++;
    if (grant !== 4'b0001 || light !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_first grant=%b light=%b busy=%b required 0001 1 1", grant, light, busy);
    end
    errs = 0;
    for (int k = 1; k <= 200; k++) begin
      exp_l = (((k - 1) / 25) % 2) == 0;
      if (grant !== 4'b0001 || light !== exp_l || done !== 4'b0) errs++;
      step(1);
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL single_pattern bad_cycles=%0d required 0", errs);
    end
    total++;
    if (done !== 4'b0001 || grant !== 4'b0 || light !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_done done=%b grant=%b light=%b busy=%b required 0001 0000 0 0", done, grant, light, busy);
    end
    req = '0;
    step(1);
    total++;
    if (done !== 4'b0 || grant !== 4'b0) begin
      bad++;
      $display("FAIL single_done_once done=%b grant=%b required 0000 0000", done, grant);
    end
  endtask

  task automatic test_round_robin();
    int errs;
    logic exp_l;
    logic [3:0] exp;
    do_reset();
    half_period = {4{7'd1}};
    req = 4'hF;
    step(1);
    for (int g = 0; g < 4; g++) begin
      exp = 4'b0001 << g;
      errs = 0;
      for (int k = 1; k <= 16; k++) begin
        exp_l = (((k - 1) / 2) % 2) == 0;
        if (grant !== exp || light !== exp_l) errs++;
        step(1);
      end
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL rr_grant_%0d bad_cycles=%0d required 0 (expected grant %b)", g, errs, exp);
      end
      total++;
      if (done !== exp || grant !== 4'b0 || light !== 1'b0) begin
        bad++;
        $display("FAIL rr_gap_%0d done=%b grant=%b light=%b required %b 0000 0", g, done, grant, light, exp);
      end
      step(1);
    end
    total++;
    if (grant !== 4'b0001) begin
      bad++;
      $display("FAIL rr_wrap grant=%b required 0001", grant);
    end
    req = '0;
    step(2);
  endtask

  task automatic test_abort();
    do_reset();
    half_period = {4{7'd24}};
    req = 4'b0101;
    step(1);
    total++;
    if (grant !== 4'b0001) begin
      bad++;
      $display("FAIL abort_setup grant=%b required 0001", grant);
    end
    step(9);
    req = 4'b0100;
    step(1);
    total++;
    if (grant !== 4'b0 || light !== 1'b0 || done !== 4'b0) begin
      bad++;
      $display("FAIL abort_release grant=%b light=%b done=%b required 0000 0 0000", grant, light, done);
    end
    step(1);
    total++;
    if (grant !== 4'b0100 || light !== 1'b1) begin
      bad++;
      $display("FAIL abort_next grant=%b light=%b required 0100 1", grant, light);
    end
    req = '0;
    step(2);
  endtask

  task automatic test_latch();
    int errs;
    logic exp_l;
    do_reset();
    half_period = {4{7'd24}};
    req = 4'b0001;
    step(1);
    half_period[0 +: 7] = 7'd3;
    errs = 0;
    for (int k = 1; k <= 200; k++) begin
      exp_l = (((k - 1) / 25) % 2) == 0;
      if (grant !== 4'b0001 || light !== exp_l) errs++;
      step(1);
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL latch_old_hp bad_cycles=%0d required 0", errs);
    end
    total++;
    if (done !== 4'b0001 || grant !== 4'b0) begin
      bad++;
      $display("FAIL latch_done done=%b grant=%b required 0001 0000", done, grant);
    end
    step(1);
    errs = 0;
    for (int k = 1; k <= 32; k++) begin
      exp_l = (((k - 1) / 4) % 2) == 0;
      if (grant !== 4'b0001 || light !== exp_l) errs++;
      step(1);
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL latch_new_hp bad_cycles=%0d required 0", errs);
    end
    total++;
    if (done !== 4'b0001 || grant !== 4'b0) begin
      bad++;
      $display("FAIL latch_done2 done=%b grant=%b required 0001 0000", done, grant);
    end
    req = '0;
    step(1);
  endtask

  task automatic test_boundary();
    int errs;
    logic exp_l;
    do_reset();
    half_period = '0;
    req = 4'b0001;
    step(1);
    errs = 0;
    for (int k = 1; k <= 8; k++) begin
      exp_l = ((k - 1) % 2) == 0;
      if (grant !== 4'b0001 || light !== exp_l) errs++;
      step(1);
    end
    total++;
    if (errs != 0 || done !== 4'b0001) begin
      bad++;
      $display("FAIL hp0_pattern bad_cycles=%0d done=%b required 0 0001", errs, done);
    end
    half_period[0 +: 7] = 7'd127;
    step(1);
    errs = 0;
    for (int k = 1; k <= 1024; k++) begin
      exp_l = (((k - 1) / 128) % 2) == 0;
      if (grant !== 4'b0001 || light !== exp_l) errs++;
      step(1);
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL hp127_pattern bad_cycles=%0d required 0", errs);
    end
    total++;
    if (done !== 4'b0001 || grant !== 4'b0 || light !== 1'b0) begin
      bad++;
      $display("FAIL hp127_done done=%b grant=%b light=%b required 0001 0000 0", done, grant, light);
    end
    req = '0;
    step(1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    half_period = {4{7'd24}};
    req = 4'b0010;
    step(1);
    total++;
    if (grant !== 4'b0010) begin
      bad++;
      $display("FAIL rmid_setup grant=%b required 0010", grant);
    end
    req = '0;
    step(1);
    req = 4'b0001;
    step(1);
    total++;
    if (grant !== 4'b0001) begin
      bad++;
      $display("FAIL rmid_owner grant=%b required 0001", grant);
    end
    step(36);
    #2 rst = 1'b1;
    #1;
    total++;
    if (grant !== 4'b0 || light !== 1'b0 || done !== 4'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rmid_async grant=%b light=%b done=%b busy=%b required all 0", grant, light, done, busy);
    end
    @(posedge clk);
    #1;
    req = 4'b1010;
    rst = 1'b0;
    step(1);
    total++;
    if (grant !== 4'b0010 || light !== 1'b1) begin
      bad++;
      $display("FAIL rmid_ptr0 grant=%b light=%b required 0010 1", grant, light);
    end
    req = '0;
    step(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_latch();
    test_boundary();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
